// File: rtl/mips_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_muldiv_pkg
// Description : Shared definitions for the MIPS multiply/divide unit. It holds
//               the op encodings, the FSM state encoding and the default
//               datapath width.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mips_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mips_div_step
// Description : One combinational restoring-divide iteration. It shifts the
//               next dividend bit into the partial remainder and tries to
//               subtract the divisor. The subtraction is kept only when it
//               does not go negative.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_div_step
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    // The shifted remainder is below 2^(WIDTH+1). One extra bit on the trial
    // difference therefore gives a reliable sign bit.
    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;

    // Trial subtraction followed by the restore decision
    always_comb begin
        w_shift = {rem_in, dividend_bit};
        w_trial = w_shift - {2'b00, divisor};
        q_bit   = ~w_trial[WIDTH+1];
        rem_out = q_bit ? w_trial[WIDTH:0] : w_shift[WIDTH:0];
    end

endmodule
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_muldiv_unit
// Description : Iterative MIPS multiply/divide unit that owns HI/LO.
//               MULT/MULTU use a shift-add loop and DIV/DIVU use a restoring
//               divide. Both take WIDTH iterations plus one sign-fix cycle.
//               MTHI/MTLO write HI/LO directly while the unit is idle.
//               Optional feature macro: MIPS_MULDIV_FAST_MUL_EN. When it is
//               defined, MULT/MULTU use a single-cycle combinational
//               multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_muldiv_unit
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_opnd;     // multiplicand, or divisor
    logic [2*WIDTH-1:0] r_acc;      // product accumulator; low half is dividend/quotient
    logic [WIDTH:0]     r_rem;      // partial remainder
    logic               r_is_div;
    logic               r_neg_q;    // negate product / quotient
    logic               r_neg_r;    // negate remainder (dividend was negative)
    logic               r_dbz;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz_out;

    logic               w_is_mul;
    logic               w_is_div;
    logic               w_is_signed;
    logic               w_neg;
    logic               w_go_calc;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_next;
    logic               w_q_bit;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_remv;

`ifdef MIPS_MULDIV_FAST_MUL_EN
    logic               r_fast_pend;
    logic [2*WIDTH-1:0] w_fast_mag;
    logic [2*WIDTH-1:0] w_fast_prod;
`endif

    // Decode the requested op and form signed magnitudes of the operands
    always_comb begin
        w_is_mul    = (op == OP_MULT) || (op == OP_MULTU);
        w_is_div    = (op == OP_DIV)  || (op == OP_DIVU);
        w_is_signed = (op == OP_MULT) || (op == OP_DIV);
        w_neg       = w_is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
        // The negation of the most negative value wraps to itself. Read as
        // unsigned, that is already the correct magnitude.
        w_abs_a     = (w_is_signed && A[WIDTH-1]) ? -A : A;
        w_abs_b     = (w_is_signed && B[WIDTH-1]) ? -B : B;
`ifdef MIPS_MULDIV_FAST_MUL_EN
        w_go_calc   = start && w_is_div;
        w_fast_mag  = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
        w_fast_prod = w_neg ? -w_fast_mag : w_fast_mag;
`else
        w_go_calc   = start && (w_is_mul || w_is_div);
`endif
    end

    // Shift-add step and the sign-corrected results used in FIX
    always_comb begin
        w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_prod = r_neg_q ? -r_acc : r_acc;
        w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
        w_remv = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    end

    mips_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in       (r_rem),
        .dividend_bit (r_acc[WIDTH-1]),
        .divisor      (r_opnd),
        .rem_out      (w_rem_next),
        .q_bit        (w_q_bit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_go_calc) w_state_next = ST_CALC;
            ST_CALC: if (r_cnt == CNT_W'(WIDTH - 1)) w_state_next = ST_FIX;
            ST_FIX:  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand latch, iterations, HI/LO writes and the done pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_opnd      <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_is_div    <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_dbz       <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_dbz_out   <= 1'b0;
`ifdef MIPS_MULDIV_FAST_MUL_EN
            r_fast_pend <= 1'b0;
`endif
        end else begin
`ifdef MIPS_MULDIV_FAST_MUL_EN
            r_done      <= r_fast_pend;
            r_fast_pend <= 1'b0;
`else
            r_done      <= 1'b0;
`endif
            r_dbz_out   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start && (op == OP_MTHI)) r_hi <= A;
                    if (start && (op == OP_MTLO)) r_lo <= A;
`ifdef MIPS_MULDIV_FAST_MUL_EN
                    if (start && w_is_mul) begin
                        {r_hi, r_lo} <= w_fast_prod;
                        r_fast_pend  <= 1'b1;
                    end
`endif
                    if (w_go_calc) begin
                        r_cnt    <= '0;
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_neg;
                        r_neg_r  <= w_is_div && w_is_signed && A[WIDTH-1];
                        r_dbz    <= w_is_div && (B == '0);
                        r_opnd   <= w_is_div ? w_abs_b : w_abs_a;
                        r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_abs_a : w_abs_b)};
                        r_rem    <= '0;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_is_div) begin
                        r_rem              <= w_rem_next;
                        r_acc[WIDTH-1:0]   <= {r_acc[WIDTH-2:0], w_q_bit};
                    end else begin
                        r_acc              <= {w_sum, r_acc[WIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    r_done <= 1'b1;
                    if (r_is_div) begin
                        // A zero divisor never restores, so the remainder
                        // ends as |A|. The dividend sign then rebuilds A.
                        r_lo      <= r_dbz ? '1 : w_quo;
                        r_hi      <= w_remv;
                        r_dbz_out <= r_dbz;
                    end else begin
                        {r_hi, r_lo} <= w_prod;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz_out;
    assign hi          = r_hi;
    assign lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_muldiv_unit
// Description : Scoreboard bench for mips_muldiv_unit. Directed ops push
//               their expected HI/LO, flag and latency. A monitor pops an
//               entry and compares it whenever done is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_muldiv_unit;

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010,
                           DIVU = 3'b011, MTHI = 3'b100, MTLO = 3'b101;
`ifdef MIPS_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT  = 1;
    localparam bit MUL_BUSY = 1'b0;
`else
    localparam int MUL_LAT  = 33;
    localparam bit MUL_BUSY = 1'b1;
`endif
    localparam int DIV_LAT = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          t0;
        int          lat;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    mips_muldiv_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: compare against the oldest expected entry whenever done is seen
    always begin
        @(posedge clk);
        #1;
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done=1 want done=0");
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.nm, "_hi"},  hi, mon_e.hi);
                chk({mon_e.nm, "_lo"},  lo, mon_e.lo);
                chk({mon_e.nm, "_dbz"}, {31'b0, div_by_zero}, {31'b0, mon_e.dbz});
                chk({mon_e.nm, "_lat"}, 32'(cyc - mon_e.t0), 32'(mon_e.lat));
            end
        end else if (div_by_zero) begin
            total++;
            bad++;
            $display("FAIL dbz_without_done: got div_by_zero=1 want 0");
        end
    end

    // Drive one start pulse from a negedge. Optionally push the expected result.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input int lat, input string nm);
        exp_t e;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (push) begin
            e.hi  = eh;
            e.lo  = el;
            e.dbz = ed;
            e.t0  = cyc + 1;
            e.lat = lat;
            e.nm  = nm;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 3'b111;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic drain(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got pending=%0d want 0", nm, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        A     = '0;
        B     = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dbz",  {31'b0, div_by_zero}, 32'd0);
        chk("rst_hi",   hi, 32'd0);
        chk("rst_lo",   lo, 32'd0);

        // MULTU max*max, with busy watched through the whole operation
        issue(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFE, 32'h00000001, 0, MUL_LAT, "multu_max");
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            chk($sformatf("multu_busy_c%0d", k), {31'b0, busy},
                {31'b0, (MUL_BUSY && (k <= 32))});
        end
        drain("multu_max");

        issue(MULT, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, MUL_LAT, "mult_neg");
        drain("mult_neg");
        issue(MULT, 32'h80000000, 32'h80000000, 1, 32'h40000000, 32'h0, 0, MUL_LAT, "mult_minmin");
        drain("mult_minmin");
        issue(DIV, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, DIV_LAT, "div_neg");
        drain("div_neg");
        issue(DIV, 32'd7, 32'hFFFFFFFE, 1, 32'd1, 32'hFFFFFFFD, 0, DIV_LAT, "div_negb");
        drain("div_negb");

        // DIVU, then a new start in the same cycle that done is high
        issue(DIVU, 32'd7, 32'd2, 1, 32'd1, 32'd3, 0, DIV_LAT, "divu_7_2");
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (done) found = 1'b1;
        end
        chk("b2b_done_seen", {31'b0, found}, 32'd1);
        issue(DIV, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 32'h80000000, 0, DIV_LAT, "div_ovf");
        drain("div_ovf");

        issue(DIVU, 32'd5, 32'd0, 1, 32'd5, 32'hFFFFFFFF, 1, DIV_LAT, "divu_dbz");
        drain("divu_dbz");
        issue(DIV, 32'hFFFFFFFB, 32'd0, 1, 32'hFFFFFFFB, 32'hFFFFFFFF, 1, DIV_LAT, "div_dbz");
        drain("div_dbz");

        // MTHI while idle writes at once and raises no done
        issue(MTHI, 32'h00001234, 32'd0, 0, 0, 0, 0, 0, "mthi");
        chk("mthi_hi", hi, 32'h00001234);
        chk("mthi_lo", lo, 32'hFFFFFFFF);
        chk("mthi_busy", {31'b0, busy}, 32'd0);

        // MTLO while busy is ignored, and HI/LO hold until FIX
        issue(DIVU, 32'd100, 32'd7, 1, 32'd2, 32'd14, 0, DIV_LAT, "divu_100_7");
        repeat (4) @(negedge clk);
        issue(MTLO, 32'h0000DEAD, 32'd0, 0, 0, 0, 0, 0, "mtlo");
        chk("mtlo_busy_lo", lo, 32'hFFFFFFFF);
        chk("mtlo_busy_hi", hi, 32'h00001234);
        chk("mtlo_busy",    {31'b0, busy}, 32'd1);
        drain("divu_100_7");

        // Reset in the middle of a divide aborts it
        issue(DIVU, 32'd1000, 32'd3, 1, 32'd1, 32'd333, 0, DIV_LAT, "divu_abort");
        repeat (9) @(negedge clk);
        sb.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_hi",   hi, 32'd0);
        chk("abort_lo",   lo, 32'd0);
        repeat (3) @(negedge clk);

        issue(MULTU, 32'd3, 32'd4, 1, 32'd0, 32'd12, 0, MUL_LAT, "multu_3_4");
        drain("multu_3_4");

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Iterative multiply/divide unit for the MIPS core. Sits in the execute stage beside the ALU and takes the same two register operands (A = rs, B = rt).
- Owns the HI/LO registers and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Its hi/lo outputs feed the writeback mux for MFHI/MFLO.
- The datapath stalls on busy.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only while idle.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others no-op.
- A  in  WIDTH  rs operand (multiplicand / dividend / MTHI/MTLO source).
- B  in  WIDTH  rt operand (multiplier / divisor).
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse, asserted in the cycle after HI/LO update.
- div_by_zero  out  1  pulses together with done when a DIV/DIVU had B == 0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; hi = 0, lo = 0, busy = 0, done = 0, div_by_zero = 0. Reset mid-operation aborts the operation; no partial result is written.
- States: IDLE, CALC, FIX.
- IDLE, on start:
  - MTHI / MTLO: write A into hi / lo at that edge. busy stays low; no done pulse.
  - MULT / MULTU / DIV / DIVU: latch operand magnitudes. Signed ops take the absolute value; |0x80000000| is 0x80000000 read as unsigned. Latch result-sign flags, clear the counter, go to CALC; busy = 1 from the next cycle.
  - Undefined op: ignored.
- CALC: one iteration per cycle for exactly WIDTH cycles.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring divide, one quotient bit per cycle, remainder kept in a WIDTH+1 bit register.
  - When the counter reaches WIDTH-1, go to FIX.
- FIX, one cycle, then IDLE:
  - Apply the sign correction and write hi/lo.
  - Multiply: {hi, lo} = product, negated when the operand signs differ (signed op only).
  - Divide: lo = quotient, negated when the signs differ; hi = remainder, which takes the sign of the dividend.
  - done = 1 for the next cycle; busy drops in that same cycle.
- Latency: start edge E0, hi/lo valid and done high after edge E(WIDTH+1), i.e. 33 cycles for WIDTH = 32.
- Divide by zero (B == 0 for DIV or DIVU): normal latency; in FIX force lo = all ones, hi = A (original, unsigned view) and pulse div_by_zero with done.
- Signed overflow, 0x80000000 / -1: lo = 0x80000000, hi = 0. No flag.
- start while busy: ignored, including MTHI/MTLO. hi/lo are unchanged until FIX.
- start arriving in the same cycle as done: accepted, since the state is already IDLE.
- Operands A/B may change after the start edge; the unit uses its latched copies only.

Optional Feature:
- Macro: MIPS_MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU bypass CALC and compute the full product with a single-cycle combinational multiplier. The product is registered and hi/lo are written at the start edge E0; done pulses after E1, and busy stays low throughout. DIV/DIVU are unchanged.
- Undefined: all four arithmetic ops use the iterative 33-cycle path described above.

Decomposition:
- Shared package mips_muldiv_pkg holds: the op encodings (OP_MULT … OP_MTLO), the state encoding (ST_IDLE, ST_CALC, ST_FIX) and the default WIDTH.
- Sub-module mips_div_step: combinational single restoring-divide iteration. Inputs: partial remainder, dividend bit, divisor. Outputs: next remainder and quotient bit. It is instantiated once inside the unit.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> done at cycle 33; hi=0xFFFFFFFE, lo=0x00000001; busy high for cycles 1..32.
- MULT A=0xFFFFFFFD (-3), B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Run again with the fast-mul macro defined -> same result, done at cycle 1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 -> lo=3, hi=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0. DIVU A=5, B=0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done.
- MTHI A=0x1234 while idle -> hi=0x1234 next cycle, no done. MTLO issued during busy -> ignored, lo unchanged.
- Start DIVU, assert reset at cycle 10 -> next cycle busy=0, hi=lo=0, no done. A MULTU 3×4 started afterwards -> lo=12, hi=0.
